// File: rtl/icache.sv
// icache: direct-mapped instruction cache, 16-byte lines, single outstanding line fetch.
// Revision 1.0
`default_nettype none

module icache #(
  parameter int INDEX_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         if_valid,
  input  logic [31:0]  if_addr,
  output logic         if_hit,
  output logic [31:0]  if_inst,
  output logic         mc_fc_valid,
  output logic [31:0]  mc_fc_addr,
  input  logic         mc_fc_done,
  input  logic [127:0] mc_fc_line
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 28 - INDEX_W;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               req_valid_nxt;
  logic [31:0]        req_addr_nxt;
  logic               refill;

  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [127:0]       data_q [LINES];

  logic [INDEX_W-1:0] lk_index;
  logic [TAG_W-1:0]   lk_tag;
  logic [127:0]       lk_line;
  logic [INDEX_W-1:0] rf_index;
  logic [TAG_W-1:0]   rf_tag;

  // Low address bits carry no information for line lookup or install.
  logic unused_bits;
  assign unused_bits = ^{if_addr[1:0], mc_fc_addr[3:0]};

  assign lk_index = if_addr[3+INDEX_W:4];
  assign lk_tag   = if_addr[31:4+INDEX_W];
  assign lk_line  = data_q[lk_index];
  assign rf_index = mc_fc_addr[3+INDEX_W:4];
  assign rf_tag   = mc_fc_addr[31:4+INDEX_W];

  always_comb begin
    if_hit  = if_valid && valid_q[lk_index] && (tag_q[lk_index] == lk_tag);
    if_inst = '0;
    if (if_hit) begin
      case (if_addr[3:2])
        2'd0: if_inst = lk_line[31:0];
        2'd1: if_inst = lk_line[63:32];
        2'd2: if_inst = lk_line[95:64];
        2'd3: if_inst = lk_line[127:96];
      endcase
    end
  end

  always_comb begin
    state_nxt     = state;
    req_valid_nxt = mc_fc_valid;
    req_addr_nxt  = mc_fc_addr;
    refill        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rdy && if_valid && !if_hit) begin
          req_valid_nxt = 1'b1;
          req_addr_nxt  = {if_addr[31:4], 4'h0};
          state_nxt     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Refill completes even while rdy is low so the done pulse is never lost.
        if (mc_fc_done) begin
          refill        = 1'b1;
          req_valid_nxt = 1'b0;
          state_nxt     = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      mc_fc_valid <= 1'b0;
      mc_fc_addr  <= '0;
      valid_q     <= '0;
    end else begin
      state       <= state_nxt;
      mc_fc_valid <= req_valid_nxt;
      mc_fc_addr  <= req_addr_nxt;
      if (refill) begin
        valid_q[rf_index] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && refill) begin
      tag_q[rf_index]  <= rf_tag;
      data_q[rf_index] <= mc_fc_line;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_icache.sv
// tb_icache: scoreboard bench for icache; expected requests and words are queued as stimulus is driven.
`default_nettype none

module tb_icache;

  logic         clk = 1'b0;
  logic         rst;
  logic         rdy;
  logic         if_valid;
  logic [31:0]  if_addr;
  logic         if_hit;
  logic [31:0]  if_inst;
  logic         mc_fc_valid;
  logic [31:0]  mc_fc_addr;
  logic         mc_fc_done;
  logic [127:0] mc_fc_line;

  int checks = 0;
  int errors = 0;

  logic [31:0] req_q[$];
  logic [31:0] exp_q[$];

  icache #(.INDEX_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_valid(if_valid), .if_addr(if_addr),
    .if_hit(if_hit), .if_inst(if_inst),
    .mc_fc_valid(mc_fc_valid), .mc_fc_addr(mc_fc_addr),
    .mc_fc_done(mc_fc_done), .mc_fc_line(mc_fc_line)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  // Memory contents: line 0x1000 holds k*0x11111111 in word k.
  function automatic logic [31:0] mem_word(input logic [31:0] la, input int k);
    logic [31:0] kk;
    kk = k;
    return (la - 32'h1000) ^ (32'h1111_1111 * kk);
  endfunction

  function automatic logic [127:0] make_line(input logic [31:0] la);
    return {mem_word(la, 3), mem_word(la, 2), mem_word(la, 1), mem_word(la, 0)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [31:0] a, input logic exp_hit);
    logic [31:0] w;
    if_valid = 1'b1;
    if_addr  = a;
    if (exp_hit) exp_q.push_back(mem_word({a[31:4], 4'h0}, int'(a[3:2])));
    #1;
    chk($sformatf("hit_%h", a), {31'b0, if_hit}, {31'b0, exp_hit});
    if (exp_hit) begin
      w = exp_q.pop_front();
      if (if_hit) chk($sformatf("inst_%h", a), if_inst, w);
    end
  endtask

  task automatic miss_fill(input logic [31:0] a, input int dly);
    logic [31:0] la;
    la       = {a[31:4], 4'h0};
    if_valid = 1'b1;
    if_addr  = a;
    #1;
    chk($sformatf("miss_%h", a), {31'b0, if_hit}, 32'd0);
    req_q.push_back(la);
    tick();
    chk("req_valid", {31'b0, mc_fc_valid}, 32'd1);
    chk("req_addr", mc_fc_addr, req_q.pop_front());
    for (int i = 0; i < dly; i++) begin
      tick();
      chk("wait_valid", {31'b0, mc_fc_valid}, 32'd1);
      chk("addr_stable", mc_fc_addr, la);
    end
    mc_fc_done = 1'b1;
    mc_fc_line = make_line(la);
    #1;
    chk("no_bypass", {31'b0, if_hit}, 32'd0);
    chk("addr_at_done", mc_fc_addr, la);
    tick();
    mc_fc_done = 1'b0;
    mc_fc_line = '0;
    chk("valid_after_done", {31'b0, mc_fc_valid}, 32'd0);
    lookup(a, 1'b1);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; if_valid = 1'b0; if_addr = '0;
    mc_fc_done = 1'b0; mc_fc_line = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_valid", {31'b0, mc_fc_valid}, 32'd0);
    chk("rst_addr", mc_fc_addr, 32'd0);
    rdy = 1'b0;
    lookup(32'h0000_1004, 1'b0);
    lookup(32'h0000_0000, 1'b0);
    lookup(32'hFFFF_FFFC, 1'b0);
    rdy = 1'b1;

    // Cold miss then hit, with a stretched wait to check address stability.
    miss_fill(32'h0000_1004, 3);

    // Conflict eviction at index 0, then the evicted line misses again.
    miss_fill(32'h0000_2000, 1);
    lookup(32'h0000_2008, 1'b1);
    miss_fill(32'h0000_1000, 0);

    // Hit-under-miss while 0x3010 is outstanding; fetch survives if_valid dropping.
    if_valid = 1'b1; if_addr = 32'h0000_3010;
    req_q.push_back(32'h0000_3010);
    #1;
    chk("hum_miss", {31'b0, if_hit}, 32'd0);
    tick();
    chk("hum_req_valid", {31'b0, mc_fc_valid}, 32'd1);
    chk("hum_req_addr", mc_fc_addr, req_q.pop_front());
    lookup(32'h0000_1008, 1'b1);
    tick();
    lookup(32'h0000_4000, 1'b0);
    tick();
    chk("hum_no_new_valid", {31'b0, mc_fc_valid}, 32'd1);
    chk("hum_no_new_addr", mc_fc_addr, 32'h0000_3010);
    if_valid = 1'b0; if_addr = 32'h7777_0000;
    mc_fc_done = 1'b1; mc_fc_line = make_line(32'h0000_3010);
    tick();
    mc_fc_done = 1'b0;
    chk("hum_done_clear", {31'b0, mc_fc_valid}, 32'd0);
    lookup(32'h0000_3018, 1'b1);
    if_valid = 1'b0;

    // Done in IDLE must not write the array.
    mc_fc_done = 1'b1; mc_fc_line = {4{32'hDEAD_BEEF}};
    tick();
    mc_fc_done = 1'b0;
    chk("idle_done_valid", {31'b0, mc_fc_valid}, 32'd0);
    lookup(32'h0000_3014, 1'b1);
    lookup(32'h0000_100C, 1'b1);
    if_valid = 1'b0;

    // rdy low holds off the request; refill still lands with rdy low.
    rdy = 1'b0; if_valid = 1'b1; if_addr = 32'h0000_5004;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rdy0_no_req", {31'b0, mc_fc_valid}, 32'd0);
      chk("rdy0_miss", {31'b0, if_hit}, 32'd0);
    end
    req_q.push_back(32'h0000_5000);
    rdy = 1'b1;
    tick();
    chk("rdy1_req_valid", {31'b0, mc_fc_valid}, 32'd1);
    chk("rdy1_req_addr", mc_fc_addr, req_q.pop_front());
    rdy = 1'b0;
    mc_fc_done = 1'b1; mc_fc_line = make_line(32'h0000_5000);
    tick();
    mc_fc_done = 1'b0;
    chk("rdy0_done_clear", {31'b0, mc_fc_valid}, 32'd0);
    lookup(32'h0000_5004, 1'b1);
    rdy = 1'b1; if_valid = 1'b0;

    // Reset in WAIT abandons the fetch; the late done is ignored.
    if_valid = 1'b1; if_addr = 32'h0000_6000;
    tick();
    chk("rstw_req_valid", {31'b0, mc_fc_valid}, 32'd1);
    if_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstw_valid", {31'b0, mc_fc_valid}, 32'd0);
    chk("rstw_addr", mc_fc_addr, 32'd0);
    mc_fc_done = 1'b1; mc_fc_line = make_line(32'h0000_6000);
    tick();
    mc_fc_done = 1'b0;
    chk("rstw_done_valid", {31'b0, mc_fc_valid}, 32'd0);
    rdy = 1'b0;
    lookup(32'h0000_6000, 1'b0);
    lookup(32'h0000_1000, 1'b0);
    lookup(32'h0000_3010, 1'b0);
    lookup(32'h0000_5000, 1'b0);
    if_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
